// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared types and helpers for the radix-4 Booth multiplier
// Contents: FSM state enum, Booth digit flags, iteration-count function.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // Recoded Booth digit: value = (neg ? -1 : +1) * (two ? 2 : 1), or 0 when zero is set.
  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_digit_t;

  // Number of radix-4 digits covering a WIDTH-bit operand extended by two bits.
  function automatic int mul_iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// rtl/booth_r4_enc.sv - radix-4 Booth window recoder and partial-product selector
// Ports:
//   win    in   3        multiplier window {r[2i+1], r[2i], r[2i-1]}
//   m_ext  in   WIDTH+2  extended multiplicand
//   digit  out  3        recoded digit flags {neg, two, zero}
//   pp     out  WIDTH+2  digit * m_ext, two's complement
module booth_r4_enc
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       win,
  input  logic [WIDTH+1:0] m_ext,
  output booth_digit_t     digit,
  output logic [WIDTH+1:0] pp
);

  logic             is_zero;
  logic             is_neg;
  logic             is_two;
  logic [WIDTH+1:0] mag;

  always_comb begin
    is_zero = (win == 3'b000) || (win == 3'b111);
    is_neg  = win[2] && !is_zero;
    is_two  = (win == 3'b011) || (win == 3'b100);
    // Doubling cannot overflow: the extended operand carries a spare sign bit.
    mag     = is_two ? {m_ext[WIDTH:0], 1'b0} : m_ext;
    if (is_zero) begin
      pp = '0;
    end else if (is_neg) begin
      pp = -mag;
    end else begin
      pp = mag;
    end
    digit.neg  = is_neg;
    digit.two  = is_two;
    digit.zero = is_zero;
  end

endmodule

// File: rtl/mul_booth_r4.sv
// rtl/mul_booth_r4.sv - sequential radix-4 Booth multiplier, two multiplier bits per cycle
// Optional build macro: MUL_BOOTH_EARLY_EXIT_EN (skip trailing zero digits in one cycle).
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake; sign_m, sign_r, m, r are the operands
//   kill                        synchronous abort of any in-flight or pending operation
//   resp_valid/resp_ready       response handshake; result is the full 2*WIDTH product
module mul_booth_r4
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               sign_m,
  input  logic               sign_r,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   r,
  input  logic               kill,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int N     = mul_iters(WIDTH);
  localparam int OP_W  = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 4;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [OP_W-1:0]    m_q, m_d;
  // Extended multiplier with the implicit zero below its LSB; bits [2:0] are the live window.
  logic [OP_W:0]      r_q, r_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  booth_digit_t              digit;
  logic [OP_W-1:0]           pp;
  logic [OP_W-1:0]           acc_hi_sum;
  logic signed [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]          acc_step;
  logic                      step_last;
  logic                      unused_digit;

  booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
    .win   (r_q[2:0]),
    .m_ext (m_q),
    .digit (digit),
    .pp    (pp)
  );

  assign unused_digit = ^digit;

`ifdef MUL_BOOTH_EARLY_EXIT_EN
  localparam int SH_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N);
  logic            early_exit;
  logic [SH_W-1:0] shamt;
`endif

  // Datapath for one BUSY cycle: add the digit's partial product to the upper
  // half, then shift right arithmetically.
  always_comb begin
    acc_hi_sum = acc_q[ACC_W-1:OP_W] + pp;
    acc_sum    = {acc_hi_sum, acc_q[OP_W-1:0]};
`ifdef MUL_BOOTH_EARLY_EXIT_EN
    // Bits above the current window (with r_q[2] as the next overlap bit) all
    // equal means every later digit is zero, so the remaining shifts collapse
    // into one. The first BUSY cycle always takes a plain step, which keeps
    // the minimum latency at two cycles.
    early_exit = (cnt_q != '0) && ((&r_q[OP_W:2]) || !(|r_q[OP_W:2]));
    shamt      = early_exit ? {N_CNT - cnt_q, 1'b0} : SH_W'(2);
    acc_step   = acc_sum >>> shamt;
    step_last  = early_exit || (cnt_q == LAST_CNT);
`else
    acc_step   = acc_sum >>> 2;
    step_last  = (cnt_q == LAST_CNT);
`endif
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    m_d        = m_q;
    r_d        = r_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
      end
      ST_BUSY: begin
        if (!kill) begin
          acc_d = acc_step;
          r_d   = {{2{r_q[OP_W]}}, r_q[OP_W:2]};
          cnt_d = cnt_q + CNT_ONE;
          if (step_last) begin
            state_d  = ST_DONE;
            result_d = acc_step[2*WIDTH-1:0];
          end
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        req_ready  = resp_ready;
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Kill outranks both the response handshake and a same-cycle request.
    if (kill) begin
      state_d = ST_IDLE;
    end else if (req_valid && req_ready) begin
      state_d = ST_BUSY;
      acc_d   = '0;
      m_d     = {{2{sign_m & m[WIDTH-1]}}, m};
      r_d     = {{2{sign_r & r[WIDTH-1]}}, r, 1'b0};
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      m_q      <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      m_q      <= m_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_mul_booth_r4.sv
// tb/tb_mul_booth_r4.sv - self-checking bench for mul_booth_r4 (WIDTH = 32)
module tb_mul_booth_r4;

  localparam int W = 32;
  localparam int N = W / 2 + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          sign_m;
  logic          sign_r;
  logic [W-1:0]  m_i;
  logic [W-1:0]  r_i;
  logic          kill;
  logic          resp_valid;
  logic          resp_ready;
  logic [2*W-1:0] result;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul_booth_r4 #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .sign_m     (sign_m),
    .sign_r     (sign_r),
    .m          (m_i),
    .r          (r_i),
    .kill       (kill),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result)
  );

  // Reference product: plain wide signed multiplication of the extended operands.
  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic sa, input logic sb);
    logic signed [65:0] ea, eb, p;
    ea = sa ? {{34{a[31]}}, a} : {34'b0, a};
    eb = sb ? {{34{b[31]}}, b} : {34'b0, b};
    p  = ea * eb;
    return p[63:0];
  endfunction

  // Expected latency: N, or with early exit the first step count k >= 2 after
  // which all unconsumed multiplier bits plus the overlap bit are equal.
  function automatic int exp_lat(input logic [31:0] b, input logic sb);
`ifdef MUL_BOOTH_EARLY_EXIT_EN
    logic [34:0] x;
    logic        same;
    x = {sb & b[31], sb & b[31], b, 1'b0};
    for (int k = 2; k < N; k++) begin
      same = 1'b1;
      for (int j = 2 * k; j <= 34; j++) begin
        if (x[j] !== x[34]) same = 1'b0;
      end
      if (same) return k;
    end
    return N;
`else
    return N;
`endif
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    case ($urandom_range(0, 4))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 15));
      2: v = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      3: begin
        case ($urandom_range(0, 3))
          0:       v = 32'h8000_0000;
          1:       v = 32'hFFFF_FFFF;
          2:       v = 32'h7FFF_FFFF;
          default: v = 32'h0000_0001;
        endcase
      end
      default: v = $urandom >> $urandom_range(0, 31);
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is accepted on the following posedge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sa, input logic sb);
    m_i = a; r_i = b; sign_m = sa; sign_r = sb; req_valid = 1'b1;
    #1;
    check("req_ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    m_i = $urandom; r_i = $urandom; sign_m = 1'($urandom); sign_r = 1'($urandom);
  endtask

  // Returns at the first negedge where resp_valid is high.
  task automatic wait_resp(input logic [63:0] exp, input int lat_exp, input string tag);
    int   lat;
    logic busy_bad;
    lat = -1;
    busy_bad = 1'b0;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
      if (req_ready !== 1'b0) busy_bad = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "_result"}, result, exp);
    check({tag, "_busy_req_ready"}, 64'(busy_bad), 64'd0);
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("resp_valid_after_accept", 64'(resp_valid), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                        input logic sb, input logic [63:0] exp, input string tag);
    issue(a, b, sa, sb);
    wait_resp(exp, exp_lat(b, sb), tag);
    consume();
  endtask

  initial begin
    logic [31:0] a, b;
    logic        sa, sb;
    logic        saw;

    reset = 1'b1; req_valid = 1'b0; kill = 1'b0; resp_ready = 1'b0;
    sign_m = 1'b0; sign_r = 1'b0; m_i = '0; r_i = '0;
    repeat (2) @(negedge clk);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    check("reset_result", result, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed products.
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, "uu_max");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000, "ss_min");
    run_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, "ss_m3x7");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 64'hFFFF_FFFF_0000_0001, "su_mixed");
    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 64'h0000_0000_0000_000F, "uu_5x3");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000, "us_mixed");
    run_op(32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, 64'h0, "zero_m");

    // Response held for 5 cycles with resp_ready low.
    issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    wait_resp(ref_prod(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0), exp_lat(32'h9ABC_DEF0, 1'b0), "hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_resp_valid", 64'(resp_valid), 64'd1);
      check("hold_result", result, ref_prod(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0));
    end
    consume();

    // Back-to-back: second request taken in the DONE cycle, resp_ready held high.
    issue(32'hDEAD_BEEF, 32'h5555_5555, 1'b0, 1'b0);
    wait_resp(ref_prod(32'hDEAD_BEEF, 32'h5555_5555, 1'b0, 1'b0), N, "b2b_first");
    resp_ready = 1'b1; req_valid = 1'b1;
    m_i = 32'hCAFE_F00D; r_i = 32'hA5A5_A5A5; sign_m = 1'b1; sign_r = 1'b1;
    #1;
    check("b2b_req_ready_done", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_resp(ref_prod(32'hCAFE_F00D, 32'hA5A5_A5A5, 1'b1, 1'b1), N, "b2b_second");
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("b2b_resp_valid_after", 64'(resp_valid), 64'd0);

    // Kill mid-BUSY with a competing request; a fresh request follows at once.
    issue(32'h0F0F_0F0F, 32'h5555_5555, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    kill = 1'b1; req_valid = 1'b1; m_i = 32'h7; r_i = 32'h9;
    @(posedge clk);
    #1;
    kill = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("kill_busy_resp_valid", 64'(resp_valid), 64'd0);
    check("kill_busy_req_ready", 64'(req_ready), 64'd1);
    run_op(32'h0000_0123, 32'h3333_3333, 1'b0, 1'b0, ref_prod(32'h123, 32'h3333_3333, 1'b0, 1'b0), "after_kill");

    // Kill in DONE outranks resp_ready and req_valid.
    issue(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);
    wait_resp(64'h242, exp_lat(32'h22, 1'b0), "kill_done_pre");
    kill = 1'b1; resp_ready = 1'b1; req_valid = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0; resp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("kill_done_resp_valid", 64'(resp_valid), 64'd0);
    check("kill_done_req_ready", 64'(req_ready), 64'd1);

    // Reset during BUSY drops the operation.
    issue(32'h7654_3210, 32'h5555_5555, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_busy_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy_result", result, 64'd0);
    check("rst_busy_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) saw = 1'b1;
    end
    check("rst_busy_no_resp", 64'(saw), 64'd0);

    // Randomized operands against the reference model.
    for (int i = 0; i < 1500; i++) begin
      a  = rand_op();
      b  = rand_op();
      sa = 1'($urandom);
      sb = 1'($urandom);
      run_op(a, b, sa, sb, ref_prod(a, b, sa, sb), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
